if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of `id_stage`. Holds the program counter and a word-addressed instruction memory with a loader write port. Also holds the IF/ID pipeline register that feeds `id_stage` its `i_next_pc` and `i_instruction`. Handles hazard-unit stalls, taken-branch redirects from ID, and misprediction recovery from EX by flushing the IF/ID register.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory size in 32-bit words; must be a power of two.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; word-aligned.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; 0 = reset, sampled on the rising edge of `clk`.
- `i_stall`  in  1  hazard-unit stall; PC and IF/ID hold their values.
- `i_branch_prediction`  in  1  ID predicts taken; redirect to `i_branch_target_addr`.
- `i_branch_target_addr`  in  32  predicted target from ID.
- `i_mispredict`  in  1  EX detected a misprediction; redirect to `i_correct_pc`.
- `i_correct_pc`  in  32  recovery PC from EX.
- `i_imem_we`  in  1  loader write enable.
- `i_imem_addr`  in  32  loader byte address; bits [1:0] ignored.
- `i_imem_wdata`  in  32  loader write word.
- `o_pc`  out  32  current PC, i.e. the address being fetched.
- `o_next_pc`  out  32  IF/ID: PC+4 of the latched instruction.
- `o_instruction`  out  32  IF/ID: latched instruction word.
- `o_valid`  out  1  IF/ID: 1 = real instruction, 0 = bubble.

## Operation
- Fetch is combinational: `fetch_word = imem[pc[log2(IMEM_DEPTH)+1:2]]` when `pc < 4*IMEM_DEPTH`; otherwise 32'h0000_0000 (NOP).
- `pc_plus4 = pc + 4`, modulo 2^32; wrap-around is allowed.
- PC update priority, highest first:
  - reset: `RESET_PC`.
  - `i_mispredict`: `{i_correct_pc[31:2],2'b00}`.
  - `i_stall`: hold.
  - `i_branch_prediction`: `{i_branch_target_addr[31:2],2'b00}`.
  - otherwise: `pc_plus4`.
- IF/ID update, using the same priority:
  - reset: instruction 0, next_pc 0, valid 0.
  - mispredict: bubble (instruction 0, next_pc 0, valid 0).
  - stall: hold all three.
  - prediction: bubble, because the word fetched this cycle is the sequential, wrong-path instruction.
  - otherwise: `{fetch_word, pc_plus4, 1}`.
- Mispredict overrides stall: the stalled ID instruction is wrong-path and is discarded.
- Stall overrides prediction: ID re-presents the branch next cycle and re-asserts the prediction then.
- Loader writes: on the rising edge when `i_imem_we=1`, `imem[i_imem_addr index] <= i_imem_wdata`.
  - Out-of-range addresses are dropped.
  - Writes are accepted in any state, including during reset.
  - A fetch of the same word in the same cycle returns the old contents.
- Memory contents are not cleared by reset; they are initialised to 0 at elaboration.

## Timing
- Reset values: `o_pc=RESET_PC`, `o_next_pc=0`, `o_instruction=0`, `o_valid=0`.
- After reset deasserts, the first valid instruction appears on IF/ID one edge later.
- Latency is 1 cycle from the PC holding address A to the IF/ID register holding `imem[A]` with `o_next_pc=A+4`.
- Throughput: 1 instruction per cycle with no stall or redirect.
- Predicted-taken branch costs 1 bubble: prediction seen at edge n; target fetched in cycle n+1; target instruction valid in IF/ID after edge n+1.
- Misprediction costs 1 bubble in IF/ID. Flushing ID/EX is the downstream register's responsibility.
- Reset asserted mid-stall or mid-redirect wins unconditionally on that edge.
- `i_stall` held for k cycles freezes `o_pc`, `o_instruction`, `o_next_pc` and `o_valid` for k edges; fetch resumes on the first edge with `i_stall=0`.

## Test plan
- Load `imem[0..3]=11,22,33,44`, release reset.
  - IF/ID shows (11,4,1), (22,8,1), (33,12,1), (44,16,1) on successive edges; `o_pc` steps 0,4,8,12,16.
- Assert `i_stall` for 2 cycles while `o_pc=8`.
  - `o_pc` stays 8 and IF/ID stays (22,8,1) for 2 edges; then (33,12,1).
- `i_branch_prediction=1`, target 32'h40, at `o_pc=8`.
  - Next edge: `o_pc=40h`, IF/ID bubble `o_valid=0`.
  - Following edge: IF/ID = (`imem[16]`, 44h, 1).
- `i_mispredict=1`, `i_correct_pc=32'h0C`, together with `i_stall=1` and `i_branch_prediction=1`.
  - `o_pc=0Ch`, IF/ID bubble; mispredict wins.
- Target 32'h42 (misaligned) and PC at 4*IMEM_DEPTH-4.
  - PC loads 40h.
  - Sequential fetch past the end returns instruction 0 with `o_valid=1`.
- Assert `reset=0` mid-stream with `i_imem_we=1` writing addr 8.
  - All outputs return to reset values.
  - After release, the new word is fetched at PC 8.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction memory
// with a loader write port, and the IF/ID pipeline register feeding id_stage.
module if_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic        i_branch_prediction,
  input  logic [31:0] i_branch_target_addr,
  input  logic        i_mispredict,
  input  logic [31:0] i_correct_pc,
  input  logic        i_imem_we,
  input  logic [31:0] i_imem_addr,
  input  logic [31:0] i_imem_wdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_instruction,
  output logic        o_valid
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic [31:0] imem_q [IMEM_DEPTH] = '{default: 32'h0000_0000};

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        valid_q, valid_d;

  logic        fetch_in_range_s;
  logic        wr_in_range_s;
  logic [31:0] fetch_word_s;
  logic [31:0] pc_plus4_s;

  // Addresses at or beyond 4*IMEM_DEPTH read as NOP and drop loader writes.
  assign fetch_in_range_s = ((pc_q >> (AW + 2)) == 32'h0000_0000);
  assign wr_in_range_s    = ((i_imem_addr >> (AW + 2)) == 32'h0000_0000);
  assign fetch_word_s     = fetch_in_range_s ? imem_q[pc_q[AW+1:2]] : 32'h0000_0000;
  assign pc_plus4_s       = pc_q + 32'd4;

  // Next-state selection: mispredict > stall > prediction > sequential.
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    next_pc_d = next_pc_q;
    valid_d   = valid_q;
    if (i_mispredict) begin
      pc_d      = {i_correct_pc[31:2], 2'b00};
      instr_d   = 32'h0000_0000;
      next_pc_d = 32'h0000_0000;
      valid_d   = 1'b0;
    end else if (i_stall) begin
      pc_d      = pc_q;
      instr_d   = instr_q;
      next_pc_d = next_pc_q;
      valid_d   = valid_q;
    end else if (i_branch_prediction) begin
      // The word fetched this cycle is the sequential wrong-path instruction.
      pc_d      = {i_branch_target_addr[31:2], 2'b00};
      instr_d   = 32'h0000_0000;
      next_pc_d = 32'h0000_0000;
      valid_d   = 1'b0;
    end else begin
      pc_d      = pc_plus4_s;
      instr_d   = fetch_word_s;
      next_pc_d = pc_plus4_s;
      valid_d   = 1'b1;
    end
  end

  // PC and IF/ID register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      next_pc_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
      valid_q   <= valid_d;
    end
  end

  // Loader port; accepted regardless of reset, same-cycle fetch sees old data.
  always_ff @(posedge clk) begin
    if (i_imem_we && wr_in_range_s) begin
      imem_q[i_imem_addr[AW+1:2]] <= i_imem_wdata;
    end
  end

  assign o_pc          = pc_q;
  assign o_next_pc     = next_pc_q;
  assign o_instruction = instr_q;
  assign o_valid       = valid_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed test-plan sequence with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_if_stage;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall, i_branch_prediction, i_mispredict, i_imem_we;
  logic [31:0] i_branch_target_addr, i_correct_pc, i_imem_addr, i_imem_wdata;
  logic [31:0] o_pc, o_next_pc, o_instruction;
  logic        o_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid;

  if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .i_stall(i_stall),
    .i_branch_prediction(i_branch_prediction),
    .i_branch_target_addr(i_branch_target_addr),
    .i_mispredict(i_mispredict), .i_correct_pc(i_correct_pc),
    .i_imem_we(i_imem_we), .i_imem_addr(i_imem_addr), .i_imem_wdata(i_imem_wdata),
    .o_pc(o_pc), .o_next_pc(o_next_pc), .o_instruction(o_instruction), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_fetch(input logic [31:0] a);
    if (a < 4 * DEPTH) return mem[a / 4];
    return 32'd0;
  endfunction

  // One clock edge: advance the model from the held inputs, then compare.
  task automatic step();
    logic [31:0] fw;
    fw = m_fetch(m_pc);
    if (!reset) begin
      m_pc = 32'd0; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
    end else if (i_mispredict) begin
      m_pc = i_correct_pc & 32'hFFFF_FFFC; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
    end else if (i_stall) begin
      m_pc = m_pc;
    end else if (i_branch_prediction) begin
      m_pc = i_branch_target_addr & 32'hFFFF_FFFC; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;
    end else begin
      m_instr = fw; m_npc = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    if (i_imem_we && i_imem_addr < 4 * DEPTH) mem[i_imem_addr / 4] = i_imem_wdata;
    @(posedge clk);
    #1;
    chk("model_pc", o_pc, m_pc);
    chk("model_instr", o_instruction, m_instr);
    chk("model_next_pc", o_next_pc, m_npc);
    chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
  endtask

  task automatic expect_ifid(input string nm, input logic [31:0] pc, input logic [31:0] ins,
                             input logic [31:0] npc, input logic v);
    chk({nm, "_pc"}, o_pc, pc);
    chk({nm, "_instr"}, o_instruction, ins);
    chk({nm, "_npc"}, o_next_pc, npc);
    chk({nm, "_valid"}, {31'd0, o_valid}, {31'd0, v});
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    i_imem_we = 1'b1; i_imem_addr = a; i_imem_wdata = d;
    step();
    i_imem_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
    reset = 1'b0; i_stall = 1'b0; i_branch_prediction = 1'b0; i_mispredict = 1'b0;
    i_branch_target_addr = 32'd0; i_correct_pc = 32'd0;
    i_imem_we = 1'b0; i_imem_addr = 32'd0; i_imem_wdata = 32'd0;
    m_pc = 32'd0; m_instr = 32'd0; m_npc = 32'd0; m_valid = 1'b0;

    // Preload during reset, including a dropped out-of-range write.
    load(32'h0, 32'd11); load(32'h4, 32'd22); load(32'h8, 32'd33); load(32'hC, 32'd44);
    load(32'h40, 32'h0000_1600); load(32'h3FC, 32'h00FF_00FF); load(32'h400, 32'hDEAD_BEEF);
    expect_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    reset = 1'b1;
    step(); expect_ifid("seq0", 32'h4, 32'd11, 32'h4, 1'b1);
    step(); expect_ifid("seq1", 32'h8, 32'd22, 32'h8, 1'b1);
    i_stall = 1'b1;
    step(); expect_ifid("stall0", 32'h8, 32'd22, 32'h8, 1'b1);
    step(); expect_ifid("stall1", 32'h8, 32'd22, 32'h8, 1'b1);
    i_stall = 1'b0;
    step(); expect_ifid("resume", 32'hC, 32'd33, 32'hC, 1'b1);

    i_branch_prediction = 1'b1; i_branch_target_addr = 32'h40;
    step(); expect_ifid("pred", 32'h40, 32'h0, 32'h0, 1'b0);
    i_branch_prediction = 1'b0;
    step(); expect_ifid("target", 32'h44, 32'h0000_1600, 32'h44, 1'b1);

    i_mispredict = 1'b1; i_correct_pc = 32'h0C; i_stall = 1'b1;
    i_branch_prediction = 1'b1; i_branch_target_addr = 32'h80;
    step(); expect_ifid("misp_wins", 32'hC, 32'h0, 32'h0, 1'b0);
    i_mispredict = 1'b0; i_stall = 1'b0; i_branch_target_addr = 32'h42;
    step(); expect_ifid("misalign", 32'h40, 32'h0, 32'h0, 1'b0);
    i_branch_prediction = 1'b0;
    i_mispredict = 1'b1; i_correct_pc = 32'h3FF;
    step(); expect_ifid("to_end", 32'h3FC, 32'h0, 32'h0, 1'b0);
    i_mispredict = 1'b0;
    step(); expect_ifid("last_word", 32'h400, 32'h00FF_00FF, 32'h400, 1'b1);
    step(); expect_ifid("past_end", 32'h404, 32'h0, 32'h404, 1'b1);

    reset = 1'b0; i_stall = 1'b1; i_imem_we = 1'b1; i_imem_addr = 32'h8; i_imem_wdata = 32'h0000_ABCD;
    step(); expect_ifid("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    reset = 1'b1; i_stall = 1'b0; i_imem_we = 1'b0;
    step(); expect_ifid("rel0", 32'h4, 32'd11, 32'h4, 1'b1);
    step(); expect_ifid("rel1", 32'h8, 32'd22, 32'h8, 1'b1);
    step(); expect_ifid("new_word", 32'hC, 32'h0000_ABCD, 32'hC, 1'b1);

    // Randomized traffic; targets cluster in memory with occasional far/wrapping ones.
    for (int c = 0; c < 3000; c++) begin
      reset               = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      i_stall             = ($urandom_range(0, 99) < 20);
      i_branch_prediction = ($urandom_range(0, 99) < 15);
      i_mispredict        = ($urandom_range(0, 99) < 8);
      i_imem_we           = ($urandom_range(0, 99) < 30);
      i_imem_addr         = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 1100);
      i_imem_wdata        = $urandom;
      i_branch_target_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                                         : $urandom_range(0, 1100);
      i_correct_pc        = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 1100);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
